// File: rtl/ecap5_dwbmem_stream_loader.sv
// Byte-stream to Wishbone loader: packs bytes into LE words, writes to DWBMEM.
// Define ECAP5_DWBMEM_LOADER_CHECKSUM_EN to add checksum_o (sum of acked words).
//
// Ports:
//   clk_i, rst_i            clock, async active-high reset
//   start_i, abort_i        control; base_adr_i/word_count_i latched on start
//   busy_o, done_o, err_o   status (done one-cycle pulse, err sticky timeout)
//   s_data_i/s_valid_i/s_ready_o   byte stream sink
//   wb_*                    pipelined Wishbone write master
//   checksum_o              only with ECAP5_DWBMEM_LOADER_CHECKSUM_EN
module ecap5_dwbmem_stream_loader #(
  parameter int CNT_W       = 9,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [31:0]      base_adr_i,
  input  logic [CNT_W:0]   word_count_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  input  logic [7:0]       s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic [31:0]      wb_adr_o,
  output logic [31:0]      wb_dat_o,
  input  logic [31:0]      wb_dat_i,
  output logic             wb_we_o,
  output logic [3:0]       wb_sel_o,
  output logic             wb_stb_o,
  input  logic             wb_ack_i,
  output logic             wb_cyc_o,
  input  logic             wb_stall_i
`ifdef ECAP5_DWBMEM_LOADER_CHECKSUM_EN
  ,
  output logic [31:0]      checksum_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_REQ,
    S_WAIT_ACK,
    S_DONE
  } state_t;

  localparam int TO_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]  TO_ONE  = 1;
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W:0]   IDX_ONE = 1;

  state_t state_q, state_d;

  logic [31:0]     base_q;
  logic [CNT_W:0]  count_q;
  logic [CNT_W:0]  idx_q;
  logic [CNT_W:0]  idx_inc;
  logic [1:0]      lane_q;
  logic [31:0]     word_q;
  logic [TO_W-1:0] to_q;

  logic            busy_d, done_d, err_d, ready_d;
  logic            stb_d, cyc_d, we_d;
  logic [3:0]      sel_d;
  logic [31:0]     adr_d, dat_d;

  logic byte_fire;
  logic start_ok;
  logic ack_ok;
  logic to_hit;
  logic last_word;

  // Write-only master: read data bus has no consumer.
  logic unused_dat;
  assign unused_dat = ^wb_dat_i;

  assign byte_fire = s_ready_o & s_valid_i;
  assign start_ok  = (state_q == S_IDLE) & start_i & ~abort_i;
  assign ack_ok    = (state_q == S_WAIT_ACK) & wb_ack_i & ~abort_i;
  assign to_hit    = (to_q == TO_LAST);
  assign idx_inc   = idx_q + IDX_ONE;
  assign last_word = (idx_inc == count_q);

  // State register and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      s_ready_o <= 1'b0;
      wb_adr_o  <= '0;
      wb_dat_o  <= '0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= '0;
      wb_stb_o  <= 1'b0;
      wb_cyc_o  <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_o    <= busy_d;
      done_o    <= done_d;
      err_o     <= err_d;
      s_ready_o <= ready_d;
      wb_adr_o  <= adr_d;
      wb_dat_o  <= dat_d;
      wb_we_o   <= we_d;
      wb_sel_o  <= sel_d;
      wb_stb_o  <= stb_d;
      wb_cyc_o  <= cyc_d;
    end
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (word_count_i == '0)
              state_d = S_DONE;
            else
              state_d = S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (byte_fire && lane_q == 2'd3)
            state_d = S_REQ;
        end
        S_REQ: begin
          if (!wb_stall_i)
            state_d = S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (wb_ack_i)
            state_d = last_word ? S_DONE : S_COLLECT;
          else if (to_hit)
            state_d = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they land in flops
  always_comb begin
    busy_d  = (state_d == S_COLLECT) |
              (state_d == S_REQ) |
              (state_d == S_WAIT_ACK);
    done_d  = (state_d == S_DONE);
    ready_d = (state_d == S_COLLECT);
    stb_d   = (state_d == S_REQ);
    cyc_d   = (state_d == S_REQ) |
              (state_d == S_WAIT_ACK);
    we_d    = stb_d;
    sel_d   = stb_d ? 4'hF : 4'h0;
    adr_d   = wb_adr_o;
    dat_d   = wb_dat_o;
    err_d   = err_o;
    // Request word is built from the three stored bytes plus the
    // byte arriving this cycle, so stb rises right after the 4th byte.
    if (state_q == S_COLLECT && state_d == S_REQ) begin
      adr_d = base_q + 32'(idx_q);
      dat_d = {s_data_i, word_q[23:0]};
    end
    if (start_ok)
      err_d = 1'b0;
    if (state_q == S_WAIT_ACK && !abort_i &&
        !wb_ack_i && to_hit)
      err_d = 1'b1;
  end

  // Transfer datapath: latched config, byte lanes, index, timeout
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      word_q  <= '0;
      to_q    <= '0;
    end else if (abort_i) begin
      lane_q  <= '0;
      word_q  <= '0;
    end else begin
      if (start_ok) begin
        base_q  <= base_adr_i;
        count_q <= word_count_i;
        idx_q   <= '0;
        lane_q  <= '0;
        word_q  <= '0;
      end
      if (byte_fire) begin
        word_q[{lane_q, 3'b000} +: 8] <= s_data_i;
        lane_q <= lane_q + 2'd1;
      end
      if (state_q == S_REQ && !wb_stall_i)
        to_q <= '0;
      if (state_q == S_WAIT_ACK) begin
        if (wb_ack_i)
          idx_q <= idx_inc;
        else
          to_q <= to_q + TO_ONE;
      end
    end
  end

`ifdef ECAP5_DWBMEM_LOADER_CHECKSUM_EN
  // Running sum of acknowledged words; survives abort
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      checksum_o <= '0;
    else if (start_ok)
      checksum_o <= '0;
    else if (ack_ok)
      checksum_o <= checksum_o + wb_dat_o;
  end
`else
  logic unused_ack_ok;
  assign unused_ack_ok = ack_ok;
`endif

endmodule

// File: tb/tb_ecap5_dwbmem_stream_loader.sv
// Scoreboard bench for ecap5_dwbmem_stream_loader.
// Expected writes queued by stimulus, checked by a negedge bus monitor.
module tb_ecap5_dwbmem_stream_loader;

  localparam int CNT_W       = 9;
  localparam int ACK_TIMEOUT = 16;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            start_i;
  logic            abort_i;
  logic [31:0]     base_adr_i;
  logic [CNT_W:0]  word_count_i;
  logic            busy_o, done_o, err_o;
  logic [7:0]      s_data_i;
  logic            s_valid_i;
  logic            s_ready_o;
  logic [31:0]     wb_adr_o, wb_dat_o, wb_dat_i;
  logic            wb_we_o;
  logic [3:0]      wb_sel_o;
  logic            wb_stb_o;
  logic            wb_ack_i;
  logic            wb_cyc_o;
  logic            wb_stall_i;
`ifdef ECAP5_DWBMEM_LOADER_CHECKSUM_EN
  logic [31:0]     checksum_o;
`endif

  always #5 clk_i = ~clk_i;

  ecap5_dwbmem_stream_loader #(
    .CNT_W(CNT_W),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .abort_i(abort_i),
    .base_adr_i(base_adr_i),
    .word_count_i(word_count_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .err_o(err_o),
    .s_data_i(s_data_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o),
    .wb_dat_i(wb_dat_i),
    .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o),
    .wb_stb_o(wb_stb_o),
    .wb_ack_i(wb_ack_i),
    .wb_cyc_o(wb_cyc_o),
    .wb_stall_i(wb_stall_i)
`ifdef ECAP5_DWBMEM_LOADER_CHECKSUM_EN
    ,
    .checksum_o(checksum_o)
`endif
  );

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_adr[$];
  logic [31:0] exp_dat[$];

  // Monitor statistics
  int   stb_run = 0;
  int   last_stb_run = 0;
  int   held_bad = 0;
  int   wait_cnt = 0;
  int   done_cnt = 0;
  int   cyc_cnt = 0;
  int   ready_cnt = 0;
  int   acc_cnt = 0;
  logic done_prev = 1'b0;
  logic acc_seen = 1'b0;
  logic [31:0] held_adr, held_dat;

  // Slave controls
  logic ack_en = 1'b1;
  logic abort_on_ack = 1'b0;
  int   stall_left = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h",
               name, act, exp);
    end
  endtask

  // Bus monitor / scoreboard
  always @(negedge clk_i) begin
    logic [31:0] ea, ed;
    acc_seen = 1'b0;
    if (!rst_i) begin
      if (wb_cyc_o) cyc_cnt++;
      if (s_ready_o) ready_cnt++;
      if (wb_cyc_o && !wb_stb_o) wait_cnt++;
      if (done_o) begin
        done_cnt++;
        chk("done_single", {63'd0, done_prev}, 64'd0);
        chk("busy_at_done", {63'd0, busy_o}, 64'd0);
      end
      done_prev = done_o;
      if (wb_stb_o) begin
        stb_run++;
        if (stb_run == 1) begin
          held_adr = wb_adr_o;
          held_dat = wb_dat_o;
        end else if (wb_adr_o !== held_adr ||
                     wb_dat_o !== held_dat) begin
          held_bad++;
        end
        if (!wb_stall_i) begin
          acc_seen = 1'b1;
          acc_cnt++;
          last_stb_run = stb_run;
          stb_run = 0;
          if (exp_adr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected adr=0x%0h dat=0x%0h required=none",
                     wb_adr_o, wb_dat_o);
          end else begin
            ea = exp_adr.pop_front();
            ed = exp_dat.pop_front();
            chk("wb_adr", 64'(wb_adr_o), 64'(ea));
            chk("wb_dat", 64'(wb_dat_o), 64'(ed));
            chk("wb_sel", 64'(wb_sel_o), 64'hF);
            chk("wb_we", {63'd0, wb_we_o}, 64'd1);
            chk("wb_cyc", {63'd0, wb_cyc_o}, 64'd1);
          end
        end
      end
    end else begin
      stb_run = 0;
      done_prev = 1'b0;
    end
  end

  // Slave model: ack one cycle after accept, optional stall/abort
  always @(posedge clk_i) begin
    #1;
    wb_ack_i = ack_en && acc_seen;
    abort_i  = abort_on_ack && wb_ack_i;
    if (wb_stb_o && stall_left > 0) begin
      wb_stall_i = 1'b1;
      stall_left--;
    end else begin
      wb_stall_i = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic start(input logic [31:0] base,
                       input logic [CNT_W:0] cnt);
    base_adr_i   = base;
    word_count_i = cnt;
    start_i      = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit sent = 0;
    s_data_i  = b;
    s_valid_i = 1'b1;
    for (int i = 0; i < 200 && !sent; i++) begin
      @(negedge clk_i);
      if (s_ready_o) begin
        @(posedge clk_i);
        #1;
        sent = 1;
      end
    end
    s_valid_i = 1'b0;
    if (!sent) begin
      checks++;
      failures++;
      $display("FAIL byte_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]);
    send_byte(w[15:8]);
    send_byte(w[23:16]);
    send_byte(w[31:24]);
    chk("req_latency", {63'd0, wb_stb_o}, 64'd1);
  endtask

  task automatic expect_wr(input logic [31:0] a,
                           input logic [31:0] d);
    exp_adr.push_back(a);
    exp_dat.push_back(d);
  endtask

  task automatic wait_done(input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_i);
      if (done_o) seen = 1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=no_done required=done");
    end
    @(posedge clk_i);
    #1;
  endtask

  int d0, c0, r0, a0;

  initial begin
    rst_i        = 1'b1;
    start_i      = 1'b0;
    abort_i      = 1'b0;
    base_adr_i   = '0;
    word_count_i = '0;
    s_data_i     = '0;
    s_valid_i    = 1'b0;
    wb_dat_i     = '0;
    wb_ack_i     = 1'b0;
    wb_stall_i   = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    // Reset state
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_done", {63'd0, done_o}, 64'd0);
    chk("rst_err", {63'd0, err_o}, 64'd0);
    chk("rst_ready", {63'd0, s_ready_o}, 64'd0);
    chk("rst_cyc", {63'd0, wb_cyc_o}, 64'd0);
    chk("rst_stb", {63'd0, wb_stb_o}, 64'd0);
    chk("rst_adr", 64'(wb_adr_o), 64'd0);
`ifdef ECAP5_DWBMEM_LOADER_CHECKSUM_EN
    chk("rst_checksum", 64'(checksum_o), 64'd0);
`endif
    @(negedge clk_i);
    rst_i = 1'b0;
    step(1);

    // 1: two words, no stall
    d0 = done_cnt;
    wait_cnt = 0;
    expect_wr(32'h10, 32'h44332211);
    expect_wr(32'h11, 32'h88776655);
    start(32'h10, 10'd2);
    chk("t1_busy", {63'd0, busy_o}, 64'd1);
    chk("t1_ready", {63'd0, s_ready_o}, 64'd1);
    send_word(32'h44332211);
    send_word(32'h88776655);
    wait_done(100);
    chk("t1_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t1_wait_cycles", 64'(wait_cnt), 64'd2);
    chk("t1_err", {63'd0, err_o}, 64'd0);
`ifdef ECAP5_DWBMEM_LOADER_CHECKSUM_EN
    chk("t1_checksum", 64'(checksum_o), 64'hCCAA8866);
`endif

    // 2: stall three cycles in REQ
    held_bad = 0;
    stall_left = 3;
    expect_wr(32'h20, 32'hDDCCBBAA);
    start(32'h20, 10'd1);
    send_word(32'hDDCCBBAA);
    wait_done(100);
    chk("t2_stb_cycles", 64'(last_stb_run), 64'd4);
    chk("t2_held", 64'(held_bad), 64'd0);

    // 3: ack never returned
    ack_en = 1'b0;
    d0 = done_cnt;
    wait_cnt = 0;
    expect_wr(32'h30, 32'h04030201);
    start(32'h30, 10'd1);
    send_word(32'h04030201);
    wait_done(100);
    chk("t3_err", {63'd0, err_o}, 64'd1);
    chk("t3_cyc", {63'd0, wb_cyc_o}, 64'd0);
    chk("t3_wait_cycles", 64'(wait_cnt), 64'(ACK_TIMEOUT));
    chk("t3_done_cnt", 64'(done_cnt - d0), 64'd1);
    ack_en = 1'b1;

    // 4: zero-length transfer
    d0 = done_cnt;
    c0 = cyc_cnt;
    r0 = ready_cnt;
    start(32'h40, 10'd0);
    chk("t4_done_next", {63'd0, done_o}, 64'd1);
    step(3);
    chk("t4_done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("t4_no_cyc", 64'(cyc_cnt - c0), 64'd0);
    chk("t4_no_ready", 64'(ready_cnt - r0), 64'd0);

    // 5a: address wrap
    expect_wr(32'hFFFFFFFF, 32'h04030201);
    expect_wr(32'h00000000, 32'h08070605);
    start(32'hFFFFFFFF, 10'd2);
    chk("t5_err_cleared", {63'd0, err_o}, 64'd0);
    send_word(32'h04030201);
    send_word(32'h08070605);
    wait_done(100);

    // 5b: full-depth transfer
    a0 = acc_cnt;
    d0 = done_cnt;
    for (int i = 0; i < 512; i++) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(4 * i);
      b1 = 8'(4 * i + 1);
      b2 = 8'(4 * i + 2);
      b3 = 8'(4 * i + 3);
      expect_wr(32'h100 + 32'(i), {b3, b2, b1, b0});
    end
    start(32'h100, 10'd512);
    for (int i = 0; i < 512; i++) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(4 * i);
      b1 = 8'(4 * i + 1);
      b2 = 8'(4 * i + 2);
      b3 = 8'(4 * i + 3);
      send_word({b3, b2, b1, b0});
    end
    wait_done(100);
    chk("t5_acks", 64'(acc_cnt - a0), 64'd512);
    chk("t5_done_cnt", 64'(done_cnt - d0), 64'd1);

    // 6a: async reset during WAIT_ACK
    ack_en = 1'b0;
    expect_wr(32'h50, 32'h5A5A1234);
    start(32'h50, 10'd1);
    send_word(32'h5A5A1234);
    step(3);
    chk("t6_in_wait", {62'd0, wb_cyc_o, wb_stb_o}, 64'd2);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    chk("t6_rst_cyc", {63'd0, wb_cyc_o}, 64'd0);
    chk("t6_rst_busy", {63'd0, busy_o}, 64'd0);
    chk("t6_rst_adr", 64'(wb_adr_o), 64'd0);
    chk("t6_rst_dat", 64'(wb_dat_o), 64'd0);
    chk("t6_rst_sel", 64'(wb_sel_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    ack_en = 1'b1;
    step(1);

    // 6b: abort in the same cycle as ack
    d0 = done_cnt;
    abort_on_ack = 1'b1;
    expect_wr(32'h60, 32'hCAFEF00D);
    start(32'h60, 10'd2);
    send_word(32'hCAFEF00D);
    step(4);
    abort_on_ack = 1'b0;
    chk("t6_abort_busy", {63'd0, busy_o}, 64'd0);
    chk("t6_abort_cyc", {63'd0, wb_cyc_o}, 64'd0);
    chk("t6_abort_ready", {63'd0, s_ready_o}, 64'd0);
    chk("t6_abort_no_done", 64'(done_cnt - d0), 64'd0);
`ifdef ECAP5_DWBMEM_LOADER_CHECKSUM_EN
    chk("t6_abort_checksum", 64'(checksum_o), 64'd0);
`endif

    chk("sb_empty", 64'(exp_adr.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
